// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef logic [2:0] funct3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam funct3_t LB  = 3'd0;
  localparam funct3_t LH  = 3'd1;
  localparam funct3_t LW  = 3'd2;
  localparam funct3_t LBU = 3'd4;
  localparam funct3_t LHU = 3'd5;

  // Stores only have byte, half and word forms; anything else is dropped.
  function automatic logic store_size_ok(input funct3_t f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and shared memory port of mem_arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  funct3_t           d_funct3;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  funct3_t           mem_funct3;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_funct3, mem_read, mem_write
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_funct3, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one shared data memory port.
// Define ARB_RR_EN for round-robin on contested requests; default is fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_SERVE = 2'(SERVE);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]        state;
  owner_e            owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  funct3_t           lat_funct3;
  logic              lat_we;
  logic              grant_d;

`ifdef ARB_RR_EN
  logic rr_ptr;
  logic contested;

  // rr_ptr == 0 favours D; it flips only when both sides asked in the same cycle.
  assign contested = bus.i_req & bus.d_req;
  assign grant_d   = bus.d_req & (~bus.i_req | ~rr_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == S_IDLE && contested) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  assign grant_d = bus.d_req;
`endif

  // Acks are registered on the SERVE->DONE edge, so they are high only during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_I;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_funct3  <= '0;
      lat_we      <= 1'b0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_req | bus.d_req) begin
            state <= S_SERVE;
            if (grant_d) begin
              owner      <= OWN_D;
              lat_addr   <= bus.d_addr;
              lat_wdata  <= bus.d_wdata;
              lat_funct3 <= bus.d_funct3;
              lat_we     <= bus.d_we;
            end else begin
              owner      <= OWN_I;
              lat_addr   <= bus.i_addr;
              lat_wdata  <= '0;
              lat_funct3 <= LW;
              lat_we     <= 1'b0;
            end
          end
        end
        S_SERVE: begin
          state <= S_DONE;
          if (owner == OWN_D) begin
            bus.d_ack <= 1'b1;
            if (!lat_we) begin
              bus.d_rdata <= bus.mem_rdata;
            end
          end else begin
            bus.i_ack   <= 1'b1;
            bus.i_rdata <= bus.mem_rdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = lat_addr;
  assign bus.mem_wdata  = lat_wdata;
  assign bus.mem_funct3 = lat_funct3;
  assign bus.mem_read   = (state == S_SERVE) & ~lat_we;
  assign bus.mem_write  = (state == S_SERVE) & lat_we & store_size_ok(lat_funct3);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a little-endian byte memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ARB_RR_EN
  localparam logic ROUND2_D_FIRST = 1'b0;
`else
  localparam logic ROUND2_D_FIRST = 1'b1;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory model: combinational sized/sign-extended read, sized write on the clock edge.
  logic [7:0] mem [0:255];
  logic [7:0] a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    a1 = bus.mem_addr + 8'd1;
    a2 = bus.mem_addr + 8'd2;
    a3 = bus.mem_addr + 8'd3;
    b0 = mem[bus.mem_addr];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    bus.mem_rdata = '0;
    case (bus.mem_funct3)
      LB:      bus.mem_rdata = {{24{b0[7]}}, b0};
      LH:      bus.mem_rdata = {{16{b1[7]}}, b1, b0};
      LW:      bus.mem_rdata = {b3, b2, b1, b0};
      LBU:     bus.mem_rdata = {24'd0, b0};
      LHU:     bus.mem_rdata = {16'd0, b1, b0};
      default: bus.mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3 == LH || bus.mem_funct3 == LW) mem[a1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3 == LW) begin
        mem[a2] <= bus.mem_wdata[23:16];
        mem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic d_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output int lat, output logic saw_wr,
                          output logic saw_rd);
    @(negedge clk);
    bus.d_req    = 1'b1;
    bus.d_we     = we;
    bus.d_addr   = addr;
    bus.d_wdata  = wdata;
    bus.d_funct3 = f3;
    lat = 0; saw_wr = 1'b0; saw_rd = 1'b0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      saw_wr |= bus.mem_write;
      saw_rd |= bus.mem_read;
      if (bus.d_ack) break;
    end
    bus.d_req = 1'b0;
  endtask

  task automatic i_access(input logic [7:0] addr, output int lat, output logic [2:0] f3_seen);
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    lat = 0; f3_seen = 3'd7;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read) f3_seen = bus.mem_funct3;
      if (bus.i_ack) break;
    end
    bus.i_req = 1'b0;
  endtask

  task automatic contest(output logic first_d, output int lat1, output int gap);
    @(negedge clk);
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 8'h20;
    bus.d_funct3 = LW;
    bus.i_req    = 1'b1;
    bus.i_addr   = 8'h10;
    lat1 = 0;
    while (lat1 < 8) begin
      @(negedge clk);
      lat1++;
      if (bus.d_ack || bus.i_ack) break;
    end
    first_d = bus.d_ack;
    if (bus.d_ack) bus.d_req = 1'b0;
    if (bus.i_ack) bus.i_req = 1'b0;
    gap = 0;
    while (gap < 8) begin
      @(negedge clk);
      gap++;
      if (bus.d_ack || bus.i_ack) break;
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat, gap;
    logic       wr, rd, first_d, ack_seen;
    logic [2:0] f3_seen;

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;
    repeat (3) @(negedge clk);
    check_output("rst_i_ack",    32'(bus.i_ack), 32'd0);
    check_output("rst_d_ack",    32'(bus.d_ack), 32'd0);
    check_output("rst_i_rdata",  bus.i_rdata, 32'd0);
    check_output("rst_d_rdata",  bus.d_rdata, 32'd0);
    check_output("rst_mem_rd",   32'(bus.mem_read), 32'd0);
    check_output("rst_mem_wr",   32'(bus.mem_write), 32'd0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;

    d_access(1'b1, 8'h10, 32'hDEADBEEF, LW, lat, wr, rd);
    check_output("sw_latency", 32'(lat), 32'd2);
    check_output("sw_write",   32'(wr), 32'd1);
    check_output("sw_noread",  32'(rd), 32'd0);
    check_output("sw_d_rdata_held", bus.d_rdata, 32'd0);

    i_access(8'h10, lat, f3_seen);
    check_output("i_latency", 32'(lat), 32'd2);
    check_output("i_rdata",   bus.i_rdata, 32'hDEADBEEF);
    check_output("i_funct3",  32'(f3_seen), 32'd2);
    check_output("i_no_d_ack", 32'(bus.d_ack), 32'd0);

    d_access(1'b1, 8'h20, 32'h0, LW, lat, wr, rd);
    d_access(1'b1, 8'h20, 32'h11223344, LB, lat, wr, rd);
    check_output("sb_write", 32'(wr), 32'd1);
    d_access(1'b0, 8'h20, 32'h0, LBU, lat, wr, rd);
    check_output("lbu_20", bus.d_rdata, 32'h00000044);
    check_output("lbu_read", 32'(rd), 32'd1);
    d_access(1'b0, 8'h20, 32'h0, LW, lat, wr, rd);
    check_output("lw_20_after_sb", bus.d_rdata, 32'h00000044);

    d_access(1'b1, 8'h21, 32'h00000080, LB, lat, wr, rd);
    d_access(1'b0, 8'h21, 32'h0, LB, lat, wr, rd);
    check_output("lb_neg", bus.d_rdata, 32'hFFFFFF80);
    d_access(1'b0, 8'h20, 32'h0, LH, lat, wr, rd);
    check_output("lh_neg", bus.d_rdata, 32'hFFFF8044);
    d_access(1'b0, 8'h20, 32'h0, LHU, lat, wr, rd);
    check_output("lhu", bus.d_rdata, 32'h00008044);

    d_access(1'b1, 8'h20, 32'hAAAAAAAA, 3'd3, lat, wr, rd);
    check_output("bad_store_ack_latency", 32'(lat), 32'd2);
    check_output("bad_store_no_write", 32'(wr), 32'd0);
    check_output("bad_store_d_rdata_held", bus.d_rdata, 32'h00008044);
    d_access(1'b0, 8'h20, 32'h0, LW, lat, wr, rd);
    check_output("bad_store_mem_unchanged", bus.d_rdata, 32'h00008044);

    contest(first_d, lat, gap);
    check_output("contest1_winner_d", 32'(first_d), 32'd1);
    check_output("contest1_latency",  32'(lat), 32'd2);
    check_output("contest1_gap",      32'(gap), 32'd3);
    contest(first_d, lat, gap);
    check_output("contest2_winner_d", 32'(first_d), 32'(ROUND2_D_FIRST));
    check_output("contest2_gap",      32'(gap), 32'd3);
    check_output("contest_d_rdata",   bus.d_rdata, 32'h00008044);
    check_output("contest_i_rdata",   bus.i_rdata, 32'hDEADBEEF);

    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h30;
    bus.d_wdata = 32'h55555555; bus.d_funct3 = LW;
    @(negedge clk);
    check_output("abort_serve_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    bus.d_req = 1'b0;
    check_output("abort_no_ack",   32'(bus.d_ack), 32'd0);
    check_output("abort_mem_wr",   32'(bus.mem_write), 32'd0);
    check_output("abort_mem_rd",   32'(bus.mem_read), 32'd0);
    check_output("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("abort_d_rdata",  bus.d_rdata, 32'd0);
    check_output("abort_i_rdata",  bus.i_rdata, 32'd0);
    rst = 1'b0;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ack_seen |= bus.d_ack | bus.i_ack;
    end
    check_output("abort_no_late_ack", 32'(ack_seen), 32'd0);

    d_access(1'b0, 8'h10, 32'h0, LW, lat, wr, rd);
    check_output("post_abort_latency", 32'(lat), 32'd2);
    check_output("post_abort_lw",      bus.d_rdata, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
